// File: rtl/raycast_pkg.sv
// Shared raycaster definitions: screen geometry defaults, Q6.10 constants and
// the row classification used by the column renderer.
package raycast_pkg;

    localparam int DEF_SCREEN_H = 480;
    localparam int DEF_ROW_W    = 10;

    localparam int          FRAC_BITS = 10;
    localparam logic [15:0] ONE       = 16'h0400;

    typedef enum logic [1:0] {
        REG_CEIL  = 2'd0,
        REG_WALL  = 2'd1,
        REG_FLOOR = 2'd2
    } region_t;

endpackage

// File: rtl/column_region_cmp.sv
// Classifies a screen row against a wall column span [top, bottom).
module column_region_cmp
    import raycast_pkg::*;
#(
    parameter int ROW_W = DEF_ROW_W
) (
    input  logic [ROW_W-1:0] i_row,
    input  logic [ROW_W-1:0] i_top,
    input  logic [ROW_W-1:0] i_bottom,
    output region_t          o_region
);

    always_comb begin
        o_region = REG_FLOOR;
        if (i_row < i_top) begin
            o_region = REG_CEIL;
        end else if (i_row < i_bottom) begin
            o_region = REG_WALL;
        end
    end

endmodule

// File: rtl/wall_height_stage.sv
// Turns a Q6.10 reciprocal distance into a screen-clamped wall column through a
// two-stage valid/ready pipeline, and classifies a row against the shown column.
module wall_height_stage
    import raycast_pkg::*;
#(
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int ROW_W    = DEF_ROW_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      i_recip,
    input  logic             i_sat,
    input  logic             i_valid,
    output logic             o_ready,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [ROW_W-1:0] o_height,
    output logic [ROW_W-1:0] o_top,
    output logic [ROW_W-1:0] o_bottom,
    output logic             o_clamped,
    input  logic [ROW_W-1:0] i_row,
    output logic [1:0]       o_region
);

    localparam logic [ROW_W-1:0] H_ROWS = ROW_W'(SCREEN_H);

    logic             r_s1_valid;
    logic [24:0]      r_s1_prod;
    logic             r_s1_sat;
    logic             r_s1_neg;
    logic             r_o_valid;
    logic [ROW_W-1:0] r_height;
    logic [ROW_W-1:0] r_top;
    logic [ROW_W-1:0] r_bottom;
    logic             r_clamped;
    region_t          r_region;

    logic             w_s2_load;
    logic             w_s1_load;
    logic [24:0]      w_prod;
    logic [14:0]      w_raw;
    logic [ROW_W-1:0] w_height;
    logic             w_clamped;
    logic [ROW_W-1:0] w_top;
    logic [ROW_W-1:0] w_bottom;
    region_t          w_region;

    assign w_s2_load = !r_o_valid || i_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign o_ready   = w_s1_load;

    assign w_prod = 25'(i_recip[14:0]) * 25'(SCREEN_H);
    assign w_raw  = r_s1_prod[24:10];

    // Saturation wins over sign, sign wins over the magnitude clamp.
    always_comb begin
        w_height  = ROW_W'(w_raw);
        w_clamped = 1'b0;
        if (r_s1_sat) begin
            w_height  = H_ROWS;
            w_clamped = 1'b1;
        end else if (r_s1_neg) begin
            w_height  = '0;
        end else if (w_raw > 15'(SCREEN_H)) begin
            w_height  = H_ROWS;
            w_clamped = 1'b1;
        end
    end

    assign w_top    = (H_ROWS - w_height) >> 1;
    assign w_bottom = w_top + w_height;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_prod  <= '0;
            r_s1_sat   <= 1'b0;
            r_s1_neg   <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= i_valid;
            r_s1_prod  <= w_prod;
            r_s1_sat   <= i_sat;
            r_s1_neg   <= i_recip[15];
        end
    end

    // Column data only changes when a real stage-1 entry moves forward, so the
    // last column stays on the outputs for row classification after draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_o_valid <= 1'b0;
            r_height  <= '0;
            r_top     <= '0;
            r_bottom  <= '0;
            r_clamped <= 1'b0;
        end else if (w_s2_load) begin
            r_o_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_height  <= w_height;
                r_top     <= w_top;
                r_bottom  <= w_bottom;
                r_clamped <= w_clamped;
            end
        end
    end

    column_region_cmp #(
        .ROW_W (ROW_W)
    ) u_region_cmp (
        .i_row    (i_row),
        .i_top    (r_top),
        .i_bottom (r_bottom),
        .o_region (w_region)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_region <= REG_CEIL;
        end else begin
            r_region <= w_region;
        end
    end

    assign o_valid   = r_o_valid;
    assign o_height  = r_height;
    assign o_top     = r_top;
    assign o_bottom  = r_bottom;
    assign o_clamped = r_clamped;
    assign o_region  = r_region;

endmodule
